// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone data-memory master.
package wb_pkg;

    localparam int unsigned WB_AW    = 32;
    localparam int unsigned WB_DW    = 32;
    localparam int unsigned WB_SELW  = 4;
    localparam int unsigned TO_CNT_W = 8;

    localparam logic [WB_DW-1:0] ERR_DATA_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_e;

    // Request payload held on the Wishbone outputs for the whole cycle.
    typedef struct packed {
        logic [WB_AW-1:0]   adr;
        logic [WB_DW-1:0]   dat;
        logic [WB_SELW-1:0] sel;
        logic               we;
    } wb_req_t;

endpackage : wb_pkg

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle watchdog: counts unanswered cycles, flags terminal count TIMEOUT-1.
module wb_timeout_cnt
    import wb_pkg::*;
#(
    parameter int unsigned W       = TO_CNT_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == W'(TIMEOUT - 1));

endmodule : wb_timeout_cnt

// File: rtl/wb_dmem_master.sv
// Wishbone classic master turning one MEM-stage load/store into one bus cycle,
// stalling the pipeline until ack, error or timeout.
module wb_dmem_master
    import wb_pkg::*;
#(
    parameter int unsigned      TIMEOUT  = 255,
    parameter logic [WB_DW-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [WB_AW-1:0]   dmem_addr,
    input  logic [WB_DW-1:0]   dmem_wdata,
    input  logic [WB_SELW-1:0] dmem_be,
    input  logic               dmem_rd,
    input  logic               dmem_wr,
    output logic [WB_DW-1:0]   dmem_rdata,
    output logic               pause,
    output logic               bus_err,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic               wb_we_o,
    output logic [WB_AW-1:0]   wb_adr_o,
    output logic [WB_SELW-1:0] wb_sel_o,
    output logic [WB_DW-1:0]   wb_dat_o,
    input  logic [WB_DW-1:0]   wb_dat_i,
    input  logic               wb_ack_i,
    input  logic               wb_err_i
);

    state_e           state_q, state_d;
    wb_req_t          req_q, req_d;
    logic             cyc_q, cyc_d;
    logic             stb_q, stb_d;
    logic             bus_err_q, bus_err_d;
    logic [WB_DW-1:0] rdata_q, rdata_d;

    logic             req;
    logic             in_bus;
    logic             tc;
    logic             term;
    logic             is_err;
    logic [WB_DW-1:0] term_data;
    logic             unused_addr_lsb;

    assign req    = dmem_rd | dmem_wr;
    assign in_bus = (state_q == ST_BUS);

    // Byte offset is dropped; the slave sees word addresses plus lane selects.
    assign unused_addr_lsb = ^dmem_addr[1:0];

    wb_timeout_cnt #(
        .W       (TO_CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .clr_i (clr | ~in_bus),
        .en_i  (in_bus & ~term),
        .tc_o  (tc)
    );

    // Error beats ack; an ack arriving on the timeout cycle still counts as success.
    always_comb begin
        term      = in_bus & (wb_ack_i | wb_err_i | tc);
        is_err    = in_bus & (wb_err_i | (tc & ~wb_ack_i));
        term_data = is_err ? ERR_DATA : wb_dat_i;
        pause     = in_bus ? ~term : req;
        dmem_rdata = term ? term_data : rdata_q;
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        rdata_d   = rdata_q;
        bus_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    req_d.adr = {dmem_addr[WB_AW-1:2], 2'b00};
                    req_d.dat = dmem_wdata;
                    req_d.we  = dmem_wr;
                    req_d.sel = dmem_wr ? dmem_be : 4'hF;
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    state_d   = ST_BUS;
                end
            end
            ST_BUS: begin
                if (term) begin
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    rdata_d   = term_data;
                    bus_err_d = is_err;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            bus_err_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            bus_err_q <= bus_err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = stb_q;
    assign wb_we_o  = req_q.we;
    assign wb_adr_o = req_q.adr;
    assign wb_sel_o = req_q.sel;
    assign wb_dat_o = req_q.dat;
    assign bus_err  = bus_err_q;

endmodule : wb_dmem_master

// File: tb/tb_wb_dmem_master.sv
// Directed bench for wb_dmem_master: drives one cycle at a time, checks mid-cycle.
module tb_wb_dmem_master;

    localparam logic [31:0] ERR_D = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_rd;
    logic        dmem_wr;
    logic [31:0] dmem_rdata;
    logic        pause;
    logic        bus_err;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    int n_cmp = 0;
    int n_err = 0;

    wb_dmem_master #(
        .TIMEOUT  (4),
        .ERR_DATA (ERR_D)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_rd    (dmem_rd),
        .dmem_wr    (dmem_wr),
        .dmem_rdata (dmem_rdata),
        .pause      (pause),
        .bus_err    (bus_err),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_sel_o   (wb_sel_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling, well before the next edge.
    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        dmem_rd  = 1'b0;
        dmem_wr  = 1'b0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h0;
    endtask

    initial begin
        clr        = 1'b1;
        dmem_addr  = 32'h0;
        dmem_wdata = 32'h0;
        dmem_be    = 4'h0;
        idle_inputs();
        step(); step(); step();
        clr = 1'b0;
        settle();
        check_eq("rst_cyc",   32'(wb_cyc_o), 32'd0);
        check_eq("rst_stb",   32'(wb_stb_o), 32'd0);
        check_eq("rst_we",    32'(wb_we_o),  32'd0);
        check_eq("rst_adr",   wb_adr_o,      32'h0);
        check_eq("rst_sel",   32'(wb_sel_o), 32'h0);
        check_eq("rst_dato",  wb_dat_o,      32'h0);
        check_eq("rst_berr",  32'(bus_err),  32'd0);
        check_eq("rst_rdata", dmem_rdata,    32'h0);
        check_eq("rst_pause", 32'(pause),    32'd0);

        // Load acked combinationally at T+1.
        step();
        dmem_rd = 1'b1; dmem_addr = 32'h1000_0004;
        settle();
        check_eq("ld1_T_pause", 32'(pause),    32'd1);
        check_eq("ld1_T_cyc",   32'(wb_cyc_o), 32'd0);
        step();
        wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_0001;
        settle();
        check_eq("ld1_T1_cyc",   32'(wb_cyc_o), 32'd1);
        check_eq("ld1_T1_stb",   32'(wb_stb_o), 32'd1);
        check_eq("ld1_T1_adr",   wb_adr_o,      32'h1000_0004);
        check_eq("ld1_T1_sel",   32'(wb_sel_o), 32'hF);
        check_eq("ld1_T1_we",    32'(wb_we_o),  32'd0);
        check_eq("ld1_T1_pause", 32'(pause),    32'd0);
        check_eq("ld1_T1_rdata", dmem_rdata,    32'hCAFE_0001);
        step();
        idle_inputs();
        settle();
        check_eq("ld1_T2_cyc",   32'(wb_cyc_o), 32'd0);
        check_eq("ld1_T2_rdata", dmem_rdata,    32'hCAFE_0001);
        check_eq("ld1_T2_berr",  32'(bus_err),  32'd0);

        // Store with be=0011, acked at T+3.
        step();
        dmem_wr = 1'b1; dmem_addr = 32'h2000_0008; dmem_wdata = 32'h1122_3344; dmem_be = 4'b0011;
        settle();
        check_eq("st_T_pause", 32'(pause), 32'd1);
        step();
        settle();
        check_eq("st_T1_pause", 32'(pause),    32'd1);
        check_eq("st_T1_we",    32'(wb_we_o),  32'd1);
        check_eq("st_T1_sel",   32'(wb_sel_o), 32'h3);
        check_eq("st_T1_dato",  wb_dat_o,      32'h1122_3344);
        check_eq("st_T1_adr",   wb_adr_o,      32'h2000_0008);
        step();
        settle();
        check_eq("st_T2_pause", 32'(pause), 32'd1);
        step();
        wb_ack_i = 1'b1; wb_dat_i = 32'h5555_AAAA;
        settle();
        check_eq("st_T3_pause", 32'(pause),    32'd0);
        check_eq("st_T3_cyc",   32'(wb_cyc_o), 32'd1);
        step();
        idle_inputs();
        settle();
        check_eq("st_T4_cyc",   32'(wb_cyc_o), 32'd0);
        check_eq("st_T4_rdata", dmem_rdata,    32'h5555_AAAA);

        // Load with err and ack together at T+2; unaligned address is word-aligned.
        step();
        dmem_rd = 1'b1; dmem_addr = 32'h3000_000F;
        step();
        settle();
        check_eq("er_T1_pause", 32'(pause),    32'd1);
        check_eq("er_T1_adr",   wb_adr_o,      32'h3000_000C);
        step();
        wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'h1234_5678;
        settle();
        check_eq("er_T2_rdata", dmem_rdata,   ERR_D);
        check_eq("er_T2_pause", 32'(pause),   32'd0);
        check_eq("er_T2_berr",  32'(bus_err), 32'd0);
        step();
        idle_inputs();
        settle();
        check_eq("er_T3_berr",  32'(bus_err),  32'd1);
        check_eq("er_T3_cyc",   32'(wb_cyc_o), 32'd0);
        check_eq("er_T3_rdata", dmem_rdata,    ERR_D);
        step();
        settle();
        check_eq("er_T4_berr", 32'(bus_err), 32'd0);

        // Back-to-back loads each acked at T+1.
        step();
        dmem_rd = 1'b1; dmem_addr = 32'h4000_0000;
        step();
        wb_ack_i = 1'b1; wb_dat_i = 32'hAAAA_0001;
        settle();
        check_eq("bb_T1_rdata", dmem_rdata, 32'hAAAA_0001);
        step();
        dmem_addr = 32'h4000_0010; wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        settle();
        check_eq("bb_T2_cyc",   32'(wb_cyc_o), 32'd0);
        check_eq("bb_T2_pause", 32'(pause),    32'd1);
        check_eq("bb_T2_rdata", dmem_rdata,    32'hAAAA_0001);
        step();
        wb_ack_i = 1'b1; wb_dat_i = 32'hBBBB_0002;
        settle();
        check_eq("bb_T3_cyc",   32'(wb_cyc_o), 32'd1);
        check_eq("bb_T3_adr",   wb_adr_o,      32'h4000_0010);
        check_eq("bb_T3_rdata", dmem_rdata,    32'hBBBB_0002);
        step();
        idle_inputs();
        settle();
        check_eq("bb_T4_rdata", dmem_rdata, 32'hBBBB_0002);

        // No response: timeout after 4 bus cycles.
        step();
        dmem_rd = 1'b1; dmem_addr = 32'h6000_0000;
        for (int k = 1; k <= 3; k++) begin
            step();
            settle();
            check_eq($sformatf("to_T%0d_pause", k), 32'(pause), 32'd1);
        end
        check_eq("to_T3_rdata", dmem_rdata, 32'hBBBB_0002);
        step();
        settle();
        check_eq("to_T4_pause", 32'(pause),    32'd0);
        check_eq("to_T4_cyc",   32'(wb_cyc_o), 32'd1);
        check_eq("to_T4_rdata", dmem_rdata,    ERR_D);
        step();
        idle_inputs();
        settle();
        check_eq("to_T5_berr", 32'(bus_err),  32'd1);
        check_eq("to_T5_cyc",  32'(wb_cyc_o), 32'd0);

        // Reset in the middle of a pending store.
        step();
        dmem_wr = 1'b1; dmem_addr = 32'h5000_0000; dmem_wdata = 32'h7777_8888; dmem_be = 4'hC;
        step();
        settle();
        check_eq("cl_T1_cyc", 32'(wb_cyc_o), 32'd1);
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        idle_inputs();
        settle();
        check_eq("cl_T3_cyc",   32'(wb_cyc_o), 32'd0);
        check_eq("cl_T3_stb",   32'(wb_stb_o), 32'd0);
        check_eq("cl_T3_berr",  32'(bus_err),  32'd0);
        check_eq("cl_T3_rdata", dmem_rdata,    32'h0);
        check_eq("cl_T3_pause", 32'(pause),    32'd0);
        check_eq("cl_T3_adr",   wb_adr_o,      32'h0);
        step();
        settle();
        check_eq("cl_T4_berr", 32'(bus_err),  32'd0);
        check_eq("cl_T4_cyc",  32'(wb_cyc_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_wb_dmem_master

// File: doc/wb_dmem_master.md
# wb_dmem_master

Wishbone classic single-master bridge for the core's data-memory port. Converts one load/store request from the MEM stage into one Wishbone bus cycle. Holds the pipeline with `pause` until the cycle terminates by ack, error or timeout. Returns load data stable for the consuming cycle. Sits upstream of the slave address decode, ack mux and read-data mux; its `pause` feeds the pipeline registers and the `pc` latch.

## Interface
Parameters:
- `TIMEOUT`, 255 — bus cycles allowed without `wb_ack_i`/`wb_err_i` before forced termination; legal range 2..255.
- `ERR_DATA`, 32'h0000_0000 — load data returned on error or timeout.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` in 1 — rising-edge clock.
  - `clr` in 1 — synchronous active-high reset.
- Core side:
  - `dmem_addr` in 32 — byte address.
  - `dmem_wdata` in 32 — store data.
  - `dmem_be` in 4 — store byte enables; bit 0 = byte lane [7:0].
  - `dmem_rd` in 1 — load request.
  - `dmem_wr` in 1 — store request.
  - `dmem_rdata` out 32 — load data.
  - `pause` out 1 — pipeline stall.
  - `bus_err` out 1 — one-cycle pulse on error or timeout termination.
- Wishbone side:
  - `wb_cyc_o` out 1, `wb_stb_o` out 1, `wb_we_o` out 1.
  - `wb_adr_o` out 32, `wb_sel_o` out 4, `wb_dat_o` out 32.
  - `wb_dat_i` in 32, `wb_ack_i` in 1, `wb_err_i` in 1.

## Operation
- States: IDLE and BUS.
- IDLE: `req = dmem_rd | dmem_wr`. If `req` is set:
  - Capture the request: `wb_adr_o` ← `{dmem_addr[31:2],2'b00}`; `wb_we_o` ← `dmem_wr`.
  - `wb_sel_o` ← `dmem_be` for a store, 4'hF for a load; `wb_dat_o` ← `dmem_wdata`.
  - Set `wb_cyc_o` and `wb_stb_o` high. Go to BUS.
- If `dmem_rd` and `dmem_wr` are both high, the store wins.
- BUS: terminate on `wb_ack_i`, `wb_err_i`, or timeout count reaching `TIMEOUT`-1.
  - On termination: drop `cyc`/`stb` at the next edge and return to IDLE.
  - If `ack` and `err` occur together, `err` wins.
- `pause` is combinational: `(IDLE & req) | (BUS & ~term)`. It is low in the terminating cycle, so the pipeline advances on that edge.
- `dmem_rdata`:
  - In the BUS terminating cycle: `wb_dat_i` on ack, `ERR_DATA` on err or timeout.
  - Otherwise: `rdata_q`, which is captured at every termination; store terminations also update it.
- `bus_err` is registered. It is high for exactly the one cycle after an err or timeout termination.
- The timeout counter is 8 bits. It is cleared on entry to BUS and increments each BUS cycle without termination.
- All Wishbone outputs are registered and stay stable for the whole cycle; Wishbone classic requires no change while `stb` is high.
- Reset values:
  - State IDLE.
  - `cyc`, `stb`, `we`, `bus_err` = 0.
  - `adr`, `sel`, `dat_o` = 0.
  - `rdata_q` = 0.
  - `pause` = `IDLE & req`, purely combinational.

## Timing
- Request seen in cycle T: `pause`=1 in T; `cyc`/`stb` high from T+1.
- Fastest path: a slave that acks combinationally at T+1 gives `pause`=0 at T+1. That is a 2-cycle access with 1 stall cycle.
- Ack at T+k: `pause` is high for cycles T..T+k-1.
- Back-to-back requests: a new request in the cycle after termination is accepted from IDLE. `cyc` drops for at least one cycle between accesses.
- Timeout: with no response, termination falls in cycle T+`TIMEOUT`; `bus_err`=1 at T+`TIMEOUT`+1.
- `clr` mid-cycle: at the next edge `cyc`/`stb` go to 0 and state returns to IDLE. The aborted cycle produces no `bus_err` pulse.

## Structure
- Shared package `wb_pkg`:
  - State encodings: IDLE=1'b0, BUS=1'b1.
  - Timeout counter width of 8.
  - Default `ERR_DATA` constant.
- One sub-module, `wb_timeout_cnt`: an 8-bit counter with synchronous clear and enable, plus a terminal-count output compared against `TIMEOUT`-1.
- Wishbone output regs and `rdata_q` sit in the top module.

## Test plan
- Load from 0x1000_0004 with slave ack at T+1, data 32'hCAFE_0001 → `pause` high only in T; `adr`=0x1000_0004, `sel`=4'hF, `we`=0; `dmem_rdata`=CAFE_0001 at T+1 and held after.
- Store of 32'h1122_3344 with `be`=4'b0011 and ack at T+3 → `pause` high T..T+2; `wb_dat_o`=1122_3344, `sel`=4'h3, `we`=1; `cyc` low at T+4.
- `wb_err_i` asserted together with `ack` at T+2 on a load → `dmem_rdata`=ERR_DATA at T+2; `bus_err`=1 at T+3 only.
- No response with `TIMEOUT`=4 → termination at T+4; `pause` low at T+4; `bus_err` pulse at T+5; `cyc` low at T+5.
- Two consecutive loads, each acked at T+1 → second request accepted at T+2 with `cyc` low at T+2, high at T+3; both data words delivered in order.
- `clr` at T+2 during a pending store → `cyc`/`stb`=0 at T+3; state IDLE; `bus_err` never asserts; `rdata_q`=0.
